// File: rtl/run_controller.sv
// Host-side launcher for the core req/ack run handshake: pulses req, waits for an armed ack, times runs out.
// Optional macro ACK_SYNC_EN passes ack through a 2-flop synchronizer before it is used.
module run_controller #(
  parameter int REQ_CYCLES = 2,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_BITS   = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                go,
  input  logic                ack,
  output logic                req,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [CNT_BITS-1:0] cycle_count,
  output logic [7:0]          run_count
);

  localparam int RL_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [RL_W-1:0]     RL_LOAD  = RL_W'(REQ_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_BITS-1:0] cycle_r, cycle_s;
  logic [7:0]          runs_r, runs_s;
  logic                armed_r, armed_s;
  logic [RL_W-1:0]     rlen_r, rlen_s;
  logic                ack_s;

`ifdef ACK_SYNC_EN
  logic ack_meta_r, ack_sync_r;

  // Two-stage synchronizer for an ack coming from an unrelated clock domain
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ack_meta_r <= 1'b0;
      ack_sync_r <= 1'b0;
    end else begin
      ack_meta_r <= ack;
      ack_sync_r <= ack_meta_r;
    end
  end

  assign ack_s = ack_sync_r;
`else
  assign ack_s = ack;
`endif

  // Next-state and datapath update; ack counts only after it has been seen low this run
  always_comb begin
    state_s = state_r;
    cycle_s = cycle_r;
    runs_s  = runs_r;
    armed_s = armed_r;
    rlen_s  = rlen_r;
    case (state_r)
      S_IDLE, S_DONE, S_FAULT: begin
        if (go) begin
          state_s = S_START;
          cycle_s = {CNT_BITS{1'b0}};
          armed_s = 1'b0;
          rlen_s  = RL_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      S_START: begin
        if (rlen_r == {RL_W{1'b0}}) begin
          state_s = S_WAIT;
        end else begin
          rlen_s = rlen_r - RL_W'(1);
        end
      end
      S_WAIT: begin
        if (!ack_s) begin
          armed_s = 1'b1;
        end else begin
          armed_s = armed_r;
        end
        if (armed_r && ack_s) begin
          state_s = S_DONE;
          runs_s  = runs_r + 8'd1;
        end else if (cycle_r == CNT_LAST) begin
          state_s = S_FAULT;
          cycle_s = CNT_MAX;
        end else begin
          cycle_s = cycle_r + CNT_BITS'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      cycle_r <= {CNT_BITS{1'b0}};
      runs_r  <= 8'd0;
      armed_r <= 1'b0;
      rlen_r  <= {RL_W{1'b0}};
    end else begin
      state_r <= state_s;
      cycle_r <= cycle_s;
      runs_r  <= runs_s;
      armed_r <= armed_s;
      rlen_r  <= rlen_s;
    end
  end

  // Status outputs registered from the next state so they line up with the state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req         <= (state_s == S_START);
      busy        <= (state_s == S_START) || (state_s == S_WAIT);
      done        <= (state_s == S_DONE);
      timeout_err <= (state_s == S_FAULT);
    end
  end

  assign cycle_count = cycle_r;
  assign run_count   = runs_r;

endmodule

// File: tb/tb_run_controller.sv
// Randomized self-checking bench for run_controller; expected outcome of each run is derived from its ack vector.
module tb_run_controller;

  localparam int REQ = 2;
  localparam int TO  = 16;
  localparam int CB  = 16;
`ifdef ACK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic          ack = 1'b0;
  logic          req, busy, done, timeout_err;
  logic [CB-1:0] cycle_count;
  logic [7:0]    run_count;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  model_runs = 0;
  bit  av [0:31];

  run_controller #(.REQ_CYCLES(REQ), .TIMEOUT(TO), .CNT_BITS(CB)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .ack(ack),
    .req(req), .busy(busy), .done(done), .timeout_err(timeout_err),
    .cycle_count(cycle_count), .run_count(run_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One launch from IDLE/DONE/FAULT; the ack seen in WAIT cycle k is av[REQ+k-LAT]
  task automatic run_one(input bit noisy_go);
    int  kend = -1;
    int  last;
    bit  armed = 1'b0;
    for (int k = 0; k < TO; k++) begin
      if (armed && av[REQ + k - LAT]) begin
        kend = k;
        break;
      end
      if (!av[REQ + k - LAT]) armed = 1'b1;
    end
    last = REQ + ((kend >= 0) ? kend : TO - 1);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int t = 0; t <= last; t++) begin
      chk("req", req, (t < REQ) ? 1 : 0);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("terr_early", timeout_err, 0);
      chk("cnt_run", cycle_count, (t < REQ) ? 0 : t - REQ);
      ack = av[t];
      go  = noisy_go ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    go = 1'b0;
    if (kend >= 0) model_runs = (model_runs + 1) % 256;
    for (int h = 0; h <= int'($urandom_range(0, 2)); h++) begin
      chk("done", done, (kend >= 0) ? 1 : 0);
      chk("terr", timeout_err, (kend >= 0) ? 0 : 1);
      chk("cnt_end", cycle_count, (kend >= 0) ? kend : TO);
      chk("busy_end", busy, 0);
      chk("req_end", req, 0);
      chk("run_count", run_count, model_runs);
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    go = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_req", req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_cnt", cycle_count, 0);
      chk("rst_runs", run_count, 0);
    end
    reset_n = 1'b1;
    tick();
    chk("post_rst_req", req, 1);
    reset_n = 1'b0;
    go = 1'b0;
    tick();
    chk("rst2_req", req, 0);
    reset_n = 1'b1;
    tick();

    // Normal run: ack rises at WAIT cycle 4
    for (int i = 0; i < 32; i++) av[i] = (i >= 6);
    run_one(1'b0);

    // Stale ack held high from the previous run
    for (int i = 0; i < 32; i++) av[i] = (i < 5) || (i >= 8);
    run_one(1'b0);

    // Timeout with ack stuck low, then a fresh launch clears the fault
    for (int i = 0; i < 32; i++) av[i] = 1'b0;
    run_one(1'b0);
    for (int i = 0; i < 32; i++) av[i] = (i >= 4);
    run_one(1'b1);

    // Random ack patterns with go noise while busy
    for (int r = 0; r < 24; r++) begin
      int p = $urandom_range(0, 9);
      for (int i = 0; i < 32; i++) av[i] = ($urandom_range(0, 9) < p);
      run_one(1'b1);
    end

    // Back-to-back runs until run_count wraps
    for (int r = 0; r < 256; r++) begin
      for (int i = 0; i < 32; i++) av[i] = (i >= 3);
      run_one(1'b1);
    end

    // Reset in the middle of WAIT abandons the run
    ack = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int t = 0; t < REQ + 3; t++) tick();
    chk("mid_cnt", cycle_count, 3);
    reset_n = 1'b0;
    tick();
    model_runs = 0;
    chk("mid_req", req, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cnt_rst", cycle_count, 0);
    chk("mid_runs", run_count, 0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) av[i] = (i >= 6);
    run_one(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
